cic_interpolator: RTL

- 3-stage CIC interpolator (comb section at low rate, zero-stuff upsampler, integrator section at high rate), differential delay 1. It is the transmit-side counterpart of the 3-stage CIC decimator.
- Interpolation factor R = 2^k, k in 0..4. The block accepts one low-rate sample per R enabled cycles and emits one high-rate sample per enabled cycle.
- Gain R^2 is removed by an arithmetic shift, giving unity DC gain.
- Sits between baseband sample source and DAC / upconversion path.

---
 rtl/cic_interpolator.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cic_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : cic_interpolator
// Brief    : 3-stage CIC interpolator, R = 2^k (k = 0..4), unity DC gain.
// Revision : 1.0
// ============================================================================
module cic_interpolator #(
    parameter int WIDTH      = 16,
    parameter int BIT_GROWTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    EN,
    input  logic                    bypass,
    input  logic [2:0]              Interpolation_Factor,
    input  logic signed [WIDTH-1:0] x_n,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic signed [WIDTH-1:0] y_n,
    output logic                    y_valid
);

    localparam int c_W = WIDTH + BIT_GROWTH;
    localparam logic signed [c_W-1:0] c_YMAX = {{(BIT_GROWTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_W-1:0] c_YMIN = {{(BIT_GROWTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [3:0]            r_phase;
    logic [2:0]            r_k_reg;
    logic signed [c_W-1:0] r_d1, r_d2, r_d3;
    logic signed [c_W-1:0] r_stuff;
    logic                  r_v1;
    logic signed [c_W-1:0] r_i1, r_i2, r_i3;

    logic                  w_phase_zero;
    logic [2:0]            w_k_in;
    logic [2:0]            w_k_eff;
    logic [4:0]            w_r;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_step;
    logic signed [c_W-1:0] w_xe, w_c1, w_c2, w_c3;
    logic signed [c_W-1:0] w_i1n, w_i2n, w_i3n;
    logic [3:0]            w_sh;
    logic signed [c_W-1:0] w_shifted;
    logic signed [WIDTH-1:0] w_sat;

    assign w_phase_zero = (r_phase == 4'd0);
    assign w_k_in       = (Interpolation_Factor > 3'd4) ? 3'd4 : Interpolation_Factor;

    // A phase-0 step always coincides with a new sample, whose factor governs its burst
    assign w_k_eff = w_phase_zero ? w_k_in : r_k_reg;
    assign w_r     = 5'd1 << w_k_eff;
    assign w_last  = ({1'b0, r_phase} == (w_r - 5'd1));

    assign x_ready  = rst_n & EN & (bypass | w_phase_zero);
    assign w_accept = x_ready & x_valid;
    assign w_load   = w_accept & ~bypass;
    assign w_step   = EN & ~bypass & (~w_phase_zero | x_valid);

    // Comb section, differential delay 1
    assign w_xe = {{BIT_GROWTH{x_n[WIDTH-1]}}, x_n};
    assign w_c1 = w_xe - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_c3 = w_c2 - r_d3;

    // Integrator section; wrap-around is harmless because the comb undoes it
    assign w_i1n = r_i1 + r_stuff;
    assign w_i2n = r_i2 + w_i1n;
    assign w_i3n = r_i3 + w_i2n;

    assign w_sh      = {r_k_reg, 1'b0};
    assign w_shifted = w_i3n >>> w_sh;
    assign w_sat     = (w_shifted > c_YMAX) ? c_YMAX[WIDTH-1:0] :
                       (w_shifted < c_YMIN) ? c_YMIN[WIDTH-1:0] :
                                              w_shifted[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_k_reg <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_d3    <= '0;
            r_stuff <= '0;
            r_v1    <= 1'b0;
            r_i1    <= '0;
            r_i2    <= '0;
            r_i3    <= '0;
            y_n     <= '0;
            y_valid <= 1'b0;
        end else if (EN) begin
            if (w_step) begin
                r_phase <= w_last ? 4'd0 : r_phase + 4'd1;
                r_stuff <= w_phase_zero ? w_c3 : '0;
            end
            if (w_load) begin
                r_k_reg <= w_k_in;
                r_d1    <= w_xe;
                r_d2    <= w_c1;
                r_d3    <= w_c2;
            end
            r_v1 <= w_step;
            if (r_v1) begin
                r_i1 <= w_i1n;
                r_i2 <= w_i2n;
                r_i3 <= w_i3n;
            end
            if (bypass) begin
                y_n     <= x_n;
                y_valid <= x_valid;
            end else begin
                y_valid <= r_v1;
                if (r_v1) begin
                    y_n <= w_sat;
                end
            end
        end
    end

endmodule
`default_nettype wire
